// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame receive path.
package can_pkg;

    localparam int unsigned ID_W   = 11;
    localparam int unsigned RSV_W  = 2;
    localparam int unsigned DLC_W  = 4;
    localparam int unsigned CTRL_W = RSV_W + DLC_W;
    localparam int unsigned DATA_W = 64;
    localparam int unsigned CRC_W  = 15;
    localparam int unsigned TAIL_W = 3;
    localparam int unsigned EOF_W  = 7;
    localparam int unsigned CNT_W  = 7;
    localparam int unsigned ERR_W  = 3;

    localparam logic [TAIL_W-1:0] TAIL_PAT = 3'b101;
    localparam logic [EOF_W-1:0]  EOF_PAT  = 7'h7F;
    localparam logic [CRC_W-1:0]  CRC_POLY = 15'h4599;

    typedef enum logic [3:0] {
        ST_BUS_WAIT,
        ST_IDLE,
        ST_ID,
        ST_CTRL,
        ST_DATA,
        ST_CRC,
        ST_TAIL,
        ST_EOF,
        ST_DONE
    } can_state_e;

    typedef enum logic [ERR_W-1:0] {
        ERR_NONE = 3'd0,
        ERR_BUS  = 3'd1,
        ERR_TAIL = 3'd2,
        ERR_EOF  = 3'd3,
        ERR_CRC  = 3'd4
    } can_err_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [RSV_W-1:0]  rsv;
        logic [DLC_W-1:0]  dlc;
        logic [DATA_W-1:0] data;
        logic [CRC_W-1:0]  crc;
    } can_frame_t;

    // Payload length in bits; DLC values above 8 still carry 8 bytes.
    function automatic logic [CNT_W-1:0] data_bits(input logic [DLC_W-1:0] dlc);
        return (dlc > 4'd8) ? CNT_W'(DATA_W) : {dlc, 3'b000};
    endfunction

endpackage

// File: rtl/can_crc15.sv
// Serial CRC-15 (CAN polynomial), one bit per enabled clock, MSB first.
module can_crc15
    import can_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_bit,
    output logic [CRC_W-1:0] o_crc
);

    logic [CRC_W-1:0] r_crc;
    logic             w_fb;
    logic [CRC_W-1:0] w_crc_nxt;

    assign w_fb      = i_bit ^ r_crc[CRC_W-1];
    assign w_crc_nxt = {r_crc[CRC_W-2:0], 1'b0} ^ (w_fb ? CRC_POLY : '0);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= w_crc_nxt;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/can_frame_rx.sv
// Bit-serial receiver for the unstuffed standard CAN frame; presents each
// good frame with a one-cycle valid strobe and aborted frames with an error strobe.
module can_frame_rx
    import can_pkg::*;
#(
    parameter int unsigned IDLE_BITS = 7,
    parameter bit          CHECK_CRC = 1'b0
) (
    input  logic              can_clk,
    input  logic              reset,
    input  logic              can_hi_in,
    input  logic              can_lo_in,
    output logic [ID_W-1:0]   rx_id,
    output logic [RSV_W-1:0]  rx_rsv,
    output logic [DLC_W-1:0]  rx_dlc,
    output logic [DATA_W-1:0] rx_data,
    output logic [CRC_W-1:0]  rx_crc,
    output logic              rx_valid,
    output logic              rx_err,
    output logic [ERR_W-1:0]  rx_err_code,
    output logic              busy
);

    localparam int unsigned RC_W = (IDLE_BITS < 2) ? 1 : $clog2(IDLE_BITS + 1);

    can_state_e        r_state;
    can_state_e        w_state_nxt;
    logic [RC_W-1:0]   r_rec_cnt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  r_dbits;
    logic [ID_W-1:0]   r_id_sh;
    logic [CTRL_W-1:0] r_ctrl;
    logic [DATA_W-1:0] r_data_sh;
    logic [CRC_W-1:0]  r_crc_sh;
    can_frame_t        r_frame;
    logic              r_valid;
    logic              r_err;
    logic [ERR_W-1:0]  r_err_code;
    logic              r_busy;

    logic              w_legal;
    logic              w_bit;
    logic              w_rec;
    logic              w_dom;
    logic              w_last;
    logic              w_adv;
    logic              w_idle_reached;
    logic              w_tail_exp;
    logic              w_eof_exp;
    logic [CTRL_W-1:0] w_ctrl_shift;
    logic [CNT_W-1:0]  w_dbits_nxt;
    logic [5:0]        w_data_idx;
    logic [CRC_W-1:0]  w_crc_calc;
    logic              w_crc_ok;
    logic              w_sof;
    logic              w_done;
    logic              w_err;
    can_err_e          w_err_code;
    logic              w_crc_en;

    // Differential decode: lo carries the bit, equal lines are illegal.
    assign w_legal        = can_hi_in ^ can_lo_in;
    assign w_bit          = can_lo_in;
    assign w_rec          = w_legal & w_bit;
    assign w_dom          = w_legal & ~w_bit;
    assign w_idle_reached = (32'(r_rec_cnt) + 32'd1) >= IDLE_BITS;
    assign w_adv          = w_legal && (r_state inside {ST_ID, ST_CTRL, ST_DATA, ST_CRC, ST_TAIL, ST_EOF});
    assign w_tail_exp     = TAIL_PAT[2'(2'd2 - r_cnt[1:0])];
    assign w_eof_exp      = EOF_PAT[r_cnt[2:0]];
    assign w_ctrl_shift   = {r_ctrl[CTRL_W-2:0], w_bit};
    assign w_dbits_nxt    = data_bits(w_ctrl_shift[DLC_W-1:0]);
    assign w_data_idx     = {r_cnt[5:3], ~r_cnt[2:0]};
    assign w_crc_ok       = CHECK_CRC ? (w_crc_calc == r_crc_sh) : 1'b1;

    can_crc15 u_crc (
        .i_clk (can_clk),
        .i_rst (reset),
        .i_clr (w_sof),
        .i_en  (w_crc_en),
        .i_bit (w_bit),
        .o_crc (w_crc_calc)
    );

    // Final bit of the current field.
    always_comb begin
        w_last = 1'b0;
        case (r_state)
            ST_ID:   w_last = (r_cnt == CNT_W'(ID_W - 1));
            ST_CTRL: w_last = (r_cnt == CNT_W'(CTRL_W - 1));
            ST_DATA: w_last = (r_cnt == r_dbits - CNT_W'(1));
            ST_CRC:  w_last = (r_cnt == CNT_W'(CRC_W - 1));
            ST_TAIL: w_last = (r_cnt == CNT_W'(TAIL_W - 1));
            ST_EOF:  w_last = (r_cnt == CNT_W'(EOF_W - 1));
            default: w_last = 1'b0;
        endcase
    end

    always_ff @(posedge can_clk) begin
        if (reset) begin
            r_state <= ST_BUS_WAIT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_BUS_WAIT: if (w_rec && w_idle_reached) w_state_nxt = ST_IDLE;
            ST_IDLE: begin
                if (!w_legal)    w_state_nxt = ST_BUS_WAIT;
                else if (!w_bit) w_state_nxt = ST_ID;
            end
            ST_ID: begin
                if (!w_legal)    w_state_nxt = ST_BUS_WAIT;
                else if (w_last) w_state_nxt = ST_CTRL;
            end
            ST_CTRL: begin
                if (!w_legal)    w_state_nxt = ST_BUS_WAIT;
                else if (w_last) w_state_nxt = (w_dbits_nxt == '0) ? ST_CRC : ST_DATA;
            end
            ST_DATA: begin
                if (!w_legal)    w_state_nxt = ST_BUS_WAIT;
                else if (w_last) w_state_nxt = ST_CRC;
            end
            ST_CRC: begin
                if (!w_legal)    w_state_nxt = ST_BUS_WAIT;
                else if (w_last) w_state_nxt = ST_TAIL;
            end
            ST_TAIL: begin
                if (!w_legal || (w_bit != w_tail_exp)) w_state_nxt = ST_BUS_WAIT;
                else if (w_last)                       w_state_nxt = ST_EOF;
            end
            ST_EOF: begin
                if (!w_legal || (w_bit != w_eof_exp)) w_state_nxt = ST_BUS_WAIT;
                else if (w_last)                      w_state_nxt = ST_DONE;
            end
            // A CRC failure was flagged on entry; it restarts the idle hunt.
            ST_DONE: w_state_nxt = r_valid ? ST_IDLE : ST_BUS_WAIT;
            default: w_state_nxt = ST_BUS_WAIT;
        endcase
    end

    always_comb begin
        w_sof      = 1'b0;
        w_done     = 1'b0;
        w_err      = 1'b0;
        w_err_code = ERR_NONE;
        w_crc_en   = 1'b0;
        case (r_state)
            ST_IDLE: w_sof = w_dom;
            ST_ID, ST_CTRL, ST_DATA: begin
                w_crc_en = w_legal;
                if (!w_legal) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_BUS;
                end
            end
            ST_CRC: begin
                if (!w_legal) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_BUS;
                end
            end
            ST_TAIL: begin
                if (!w_legal) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_BUS;
                end else if (w_bit != w_tail_exp) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_TAIL;
                end
            end
            ST_EOF: begin
                if (!w_legal) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_BUS;
                end else if (w_bit != w_eof_exp) begin
                    w_err      = 1'b1;
                    w_err_code = ERR_EOF;
                end else if (w_last) begin
                    w_done = 1'b1;
                    if (!w_crc_ok) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_CRC;
                    end
                end
            end
            default: ;
        endcase
    end

    // Field shift registers, counters and registered frame outputs.
    always_ff @(posedge can_clk) begin
        if (reset) begin
            r_rec_cnt  <= '0;
            r_cnt      <= '0;
            r_dbits    <= '0;
            r_id_sh    <= '0;
            r_ctrl     <= '0;
            r_data_sh  <= '0;
            r_crc_sh   <= '0;
            r_frame    <= '0;
            r_valid    <= 1'b0;
            r_err      <= 1'b0;
            r_err_code <= '0;
            r_busy     <= 1'b0;
        end else begin
            if ((r_state != ST_BUS_WAIT) || !w_rec) begin
                r_rec_cnt <= '0;
            end else if (!w_idle_reached) begin
                r_rec_cnt <= r_rec_cnt + RC_W'(1);
            end else begin
                r_rec_cnt <= RC_W'(IDLE_BITS);
            end

            if (w_state_nxt != r_state) begin
                r_cnt <= '0;
            end else if (w_adv) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_sof) begin
                r_id_sh   <= '0;
                r_ctrl    <= '0;
                r_data_sh <= '0;
                r_crc_sh  <= '0;
                r_dbits   <= '0;
            end else if (w_legal) begin
                case (r_state)
                    ST_ID:   r_id_sh <= {r_id_sh[ID_W-2:0], w_bit};
                    ST_CTRL: begin
                        r_ctrl <= w_ctrl_shift;
                        if (w_last) r_dbits <= w_dbits_nxt;
                    end
                    ST_DATA: r_data_sh[w_data_idx] <= w_bit;
                    ST_CRC:  r_crc_sh <= {r_crc_sh[CRC_W-2:0], w_bit};
                    default: ;
                endcase
            end

            r_valid    <= w_done && !w_err;
            r_err      <= w_err;
            r_err_code <= w_err ? w_err_code : ERR_NONE;

            if (w_sof) begin
                r_busy <= 1'b1;
            end else if (w_err || w_done) begin
                r_busy <= 1'b0;
            end

            if (w_done && !w_err) begin
                r_frame.id   <= r_id_sh;
                r_frame.rsv  <= r_ctrl[CTRL_W-1:DLC_W];
                r_frame.dlc  <= r_ctrl[DLC_W-1:0];
                r_frame.data <= r_data_sh;
                r_frame.crc  <= r_crc_sh;
            end
        end
    end

    assign rx_id       = r_frame.id;
    assign rx_rsv      = r_frame.rsv;
    assign rx_dlc      = r_frame.dlc;
    assign rx_data     = r_frame.data;
    assign rx_crc      = r_frame.crc;
    assign rx_valid    = r_valid;
    assign rx_err      = r_err;
    assign rx_err_code = r_err_code;
    assign busy        = r_busy;

endmodule

// File: tb/tb_can_frame_rx.sv
// Directed bench for can_frame_rx: one instance ignoring CRC, one checking it.
module tb_can_frame_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        can_hi;
    logic        can_lo;

    logic [10:0] id0, id1;
    logic [1:0]  rsv0, rsv1;
    logic [3:0]  dlc0, dlc1;
    logic [63:0] data0, data1;
    logic [14:0] crc0, crc1;
    logic        valid0, valid1, err0, err1, busy0, busy1;
    logic [2:0]  code0, code1;

    int n_tests = 0;
    int n_fail  = 0;
    int v0 = 0, e0 = 0, v1 = 0, e1 = 0;
    int v1s, e1s, v0s;

    bit          fq[$];
    int          crc_pos;
    logic [14:0] good_crc;

    always #5 clk = ~clk;

    can_frame_rx #(.IDLE_BITS(7), .CHECK_CRC(1'b0)) dut0 (
        .can_clk(clk), .reset(reset), .can_hi_in(can_hi), .can_lo_in(can_lo),
        .rx_id(id0), .rx_rsv(rsv0), .rx_dlc(dlc0), .rx_data(data0), .rx_crc(crc0),
        .rx_valid(valid0), .rx_err(err0), .rx_err_code(code0), .busy(busy0)
    );

    can_frame_rx #(.IDLE_BITS(7), .CHECK_CRC(1'b1)) dut1 (
        .can_clk(clk), .reset(reset), .can_hi_in(can_hi), .can_lo_in(can_lo),
        .rx_id(id1), .rx_rsv(rsv1), .rx_dlc(dlc1), .rx_data(data1), .rx_crc(crc1),
        .rx_valid(valid1), .rx_err(err1), .rx_err_code(code1), .busy(busy1)
    );

    // Pulse counters, sampled mid-cycle.
    always @(negedge clk) begin
        if (valid0) v0++;
        if (err0)   e0++;
        if (valid1) v1++;
        if (err1)   e1++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic build(input logic [10:0] id, input logic [1:0] rsv, input logic [3:0] dlc,
                         input logic [63:0] data, input logic [14:0] crc, input logic [2:0] tail);
        int nb;
        fq.delete();
        nb = (dlc > 4'd8) ? 8 : int'(dlc);
        fq.push_back(1'b0);
        for (int i = 10; i >= 0; i--) fq.push_back(id[i]);
        for (int i = 1; i >= 0; i--)  fq.push_back(rsv[i]);
        for (int i = 3; i >= 0; i--)  fq.push_back(dlc[i]);
        for (int b = 0; b < nb; b++)
            for (int i = 7; i >= 0; i--) fq.push_back(data[8*b + i]);
        crc_pos = fq.size();
        for (int i = 14; i >= 0; i--) fq.push_back(crc[i]);
        for (int i = 2; i >= 0; i--)  fq.push_back(tail[i]);
        for (int i = 0; i < 7; i++)   fq.push_back(1'b1);
    endtask

    // Reference CRC-15 over SOF through the last data bit.
    function automatic logic [14:0] calc_crc();
        logic [14:0] r;
        logic        fb;
        r = '0;
        for (int i = 0; i < crc_pos; i++) begin
            fb = fq[i] ^ r[14];
            r  = {r[13:0], 1'b0};
            if (fb) r = r ^ 15'h4599;
        end
        return r;
    endfunction

    task automatic set_crc(input logic [14:0] c);
        for (int i = 0; i < 15; i++) fq[crc_pos + i] = c[14 - i];
    endtask

    task automatic drive(input logic hi, input logic lo);
        can_hi = hi;
        can_lo = lo;
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input bit b);
        drive(!b, b);
    endtask

    task automatic send_range(input int a, input int b);
        for (int i = a; i < b; i++) send_bit(fq[i]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_bit(1'b1);
    endtask

    initial begin
        reset  = 1'b1;
        can_hi = 1'b0;
        can_lo = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid", 64'(valid0), 64'd0);
        check("rst_err",   64'(err0),   64'd0);
        check("rst_busy",  64'(busy0),  64'd0);
        check("rst_id",    64'(id0),    64'd0);
        check("rst_data",  data0,       64'd0);
        check("rst_code",  64'(code0),  64'd0);
        reset = 1'b0;
        idle(8);

        // Test 1: basic two-byte frame, exact strobe timing
        build(11'h123, 2'b00, 4'd2, 64'h1289, 15'h0, 3'b101);
        send_range(0, fq.size() - 1);
        check("t1_valid_early", 64'(valid0), 64'd0);
        check("t1_busy_mid",    64'(busy0),  64'd1);
        send_range(fq.size() - 1, fq.size());
        check("t1_valid",    64'(valid0), 64'd1);
        check("t1_busy_end", 64'(busy0),  64'd0);
        check("t1_id",       64'(id0),    64'h123);
        check("t1_rsv",      64'(rsv0),   64'd0);
        check("t1_dlc",      64'(dlc0),   64'd2);
        check("t1_data",     data0,       64'h1289);
        check("t1_crc",      64'(crc0),   64'd0);
        send_bit(1'b1);
        check("t1_pulse_end", 64'(valid0), 64'd0);
        idle(8);
        check("t1_nvalid", 64'(v0), 64'd1);
        check("t1_nerr",   64'(e0), 64'd0);

        // Test 2: DLC 0
        build(11'h7FF, 2'b00, 4'd0, 64'h0, 15'h0, 3'b101);
        send_range(0, fq.size());
        idle(8);
        check("t2_nvalid", 64'(v0),   64'd2);
        check("t2_id",     64'(id0),  64'h7FF);
        check("t2_dlc",    64'(dlc0), 64'd0);
        check("t2_data",   data0,     64'd0);

        // Test 3: DLC 15 carries 8 bytes
        build(11'h3A5, 2'b10, 4'hF, 64'h0807060504030201, 15'h1234, 3'b101);
        send_range(0, fq.size());
        idle(8);
        check("t3_nvalid", 64'(v0),   64'd3);
        check("t3_id",     64'(id0),  64'h3A5);
        check("t3_rsv",    64'(rsv0), 64'd2);
        check("t3_dlc",    64'(dlc0), 64'hF);
        check("t3_data",   data0,     64'h0807060504030201);
        check("t3_crc",    64'(crc0), 64'h1234);

        // Test 4: bad tail aborts, outputs hold, recovery after 7 idle bits
        build(11'h123, 2'b00, 4'd2, 64'h1289, 15'h0, 3'b111);
        send_range(0, crc_pos + 17);
        check("t4_err",    64'(err0),  64'd1);
        check("t4_code",   64'(code0), 64'd2);
        check("t4_busy",   64'(busy0), 64'd0);
        idle(7);
        check("t4_nerr",   64'(e0),    64'd1);
        check("t4_nvalid", 64'(v0),    64'd3);
        check("t4_id_hold",   64'(id0), 64'h3A5);
        check("t4_data_hold", data0,    64'h0807060504030201);
        build(11'h001, 2'b00, 4'd1, 64'hAB, 15'h0, 3'b101);
        send_range(0, fq.size());
        send_bit(1'b1);
        check("t4_rec_nvalid", 64'(v0), 64'd4);
        check("t4_rec_id",     64'(id0), 64'h001);
        check("t4_rec_data",   data0,    64'hAB);

        // Test 5a: illegal level on the third data bit
        idle(8);
        build(11'h0F0, 2'b00, 4'd2, 64'h3355, 15'h0, 3'b101);
        send_range(0, 20);
        drive(1'b1, 1'b1);
        check("t5_err",  64'(err0),  64'd1);
        check("t5_code", 64'(code0), 64'd1);
        check("t5_busy", 64'(busy0), 64'd0);
        idle(8);
        check("t5_nerr",   64'(e0), 64'd2);
        check("t5_nvalid", 64'(v0), 64'd4);

        // Test 5b: reset in the middle of DATA
        send_range(0, 24);
        check("t5r_busy_pre", 64'(busy0), 64'd1);
        reset = 1'b1;
        send_bit(1'b1);
        check("t5r_busy",  64'(busy0),  64'd0);
        check("t5r_valid", 64'(valid0), 64'd0);
        check("t5r_err",   64'(err0),   64'd0);
        check("t5r_id",    64'(id0),    64'd0);
        check("t5r_dlc",   64'(dlc0),   64'd0);
        check("t5r_data",  data0,       64'd0);
        check("t5r_code",  64'(code0),  64'd0);
        reset = 1'b0;
        idle(8);
        check("t5r_nvalid", 64'(v0), 64'd4);
        check("t5r_nerr",   64'(e0), 64'd2);

        // Test 6: CRC checking instance
        v1s = v1;
        e1s = e1;
        build(11'h555, 2'b00, 4'd3, 64'hEEFFC0, 15'h0, 3'b101);
        good_crc = calc_crc();
        set_crc(good_crc);
        send_range(0, fq.size());
        send_bit(1'b1);
        idle(8);
        check("t6_nvalid", 64'(v1),   64'(v1s + 1));
        check("t6_nerr",   64'(e1),   64'(e1s));
        check("t6_id",     64'(id1),  64'h555);
        check("t6_data",   data1,     64'hEEFFC0);
        check("t6_crc",    64'(crc1), 64'(good_crc));
        v0s = v0;
        set_crc(good_crc ^ 15'h0100);
        send_range(0, fq.size());
        check("t6b_err",    64'(err1),   64'd1);
        check("t6b_code",   64'(code1),  64'd4);
        check("t6b_valid",  64'(valid1), 64'd0);
        check("t6b_ignore", 64'(valid0), 64'd1);
        send_bit(1'b1);
        idle(8);
        check("t6b_nvalid",   64'(v1),   64'(v1s + 1));
        check("t6b_nerr",     64'(e1),   64'(e1s + 1));
        check("t6b_crc_hold", 64'(crc1), 64'(good_crc));
        check("t6b_nvalid0",  64'(v0),   64'(v0s + 1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
